if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit five-stage pipeline.
- Owns the PC register, drives the instruction-memory address and owns the IF/ID pipeline register.
- Obeys the PC_write_en / IFID_write_en stall controls from the hazard unit, redirects on taken branches resolved in ID, and stops fetch at HLT.
- Feeds the ID stage, hazard unit and branch unit through IFID_instr, IFID_PC_plus2 and IFID_valid.

Parameters:
- DATA_W, 16: PC, address and instruction width.
- RESET_PC, 16'h0000: PC value loaded on reset.
- HLT_OPCODE, 4'b1111: opcode (instr[15:12]) that halts fetch.
- NOP_INSTR, 16'h0000: encoding placed in IF/ID on bubble/flush, always paired with IFID_valid=0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PC_write_en  in  1  1 = PC may update; 0 = hold PC (hazard stall).
- IFID_write_en  in  1  1 = IF/ID may load; 0 = hold IF/ID (hazard stall).
- branch_taken  in  1  branch in ID resolved taken this cycle.
- branch_target  in  DATA_W  redirect address, valid with branch_taken.
- imem_data  in  DATA_W  instruction at imem_addr, combinational read, same cycle.
- imem_addr  out  DATA_W  equals PC register.
- IFID_instr  out  DATA_W  registered instruction to ID.
- IFID_PC_plus2  out  DATA_W  registered PC+2 of that instruction (PCS, branch base).
- IFID_valid  out  1  IFID_instr is a real instruction.
- fetch_halted  out  1  fetch FSM in HALTED.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, IFID_instr=NOP_INSTR, IFID_PC_plus2=0, IFID_valid=0, FSM=RUN, fetch_halted=0. All outputs take these values immediately. Release is synchronous to the next clk edge.
- imem_addr = PC, combinational from the register. Single-cycle fetch latency: the instruction at PC appears on IFID_instr one edge later.
- pc_plus2 = PC + 2, modulo 2^DATA_W. 16'hFFFE wraps to 16'h0000 with no flag.
- FSM states: RUN, HALTED.
- RUN, evaluated at each edge in priority order:
  1. IFID_write_en=0: IF/ID holds. PC holds unless PC_write_en=1. branch_taken is ignored, because branch operands are unresolved during a stall.
  2. branch_taken=1: PC<=branch_target. IF/ID<=NOP_INSTR, valid=0, PC_plus2 unchanged (flushes the wrong-path fetch). Stay RUN, even if imem_data is HLT.
  3. imem_data[15:12]==HLT_OPCODE: IF/ID<=imem_data, PC_plus2<=pc_plus2, valid=1. PC holds. FSM->HALTED.
  4. Otherwise: IF/ID<=imem_data, PC_plus2<=pc_plus2, valid=1. PC<=pc_plus2 when PC_write_en=1, else PC holds.
- HALTED:
  - PC frozen and fetch_halted=1.
  - When IFID_write_en=1, IF/ID<=NOP_INSTR with valid=0 (bubbles behind HLT). When IFID_write_en=0, IF/ID holds, so the HLT stays visible to ID during a stall.
  - branch_taken is ignored.
  - Exit only via reset.
- PC_write_en=1 with IFID_write_en=0 is not a legal pairing. If it occurs, the PC follows PC_write_en and IF/ID holds; no assertion is required in RTL.
- No combinational path from any input to any IF/ID output.

Test Plan:
- Reset/sequential fetch: rst_n low, then release. Memory holds 0x1234 @0, 0x5678 @2, 0x0ABC @4. Expect imem_addr 0,2,4,6 on consecutive cycles; IFID_instr 0x1234 (PC_plus2=2), then 0x5678 (PC_plus2=4), then 0x0ABC; IFID_valid=1 from the first edge after release.
- Stall: PC=6, PC_write_en=IFID_write_en=0 for 2 cycles. Expect PC=6 and IF/ID unchanged for 2 cycles, then PC=8 after release.
- Branch flush: PC=8, branch_taken=1, target=0x0040. Expect next PC=0x0040, IFID_valid=0, IFID_instr=0x0000; the cycle after, IFID_instr=mem[0x40], valid=1.
- Branch during stall: branch_taken=1 with IFID_write_en=0. Expect PC and IF/ID unchanged; redirect occurs only on the first unstalled cycle with branch_taken=1.
- HLT: 0xF000 @0x10. Expect IFID_instr=0xF000, valid=1 once, then valid=0 bubbles. PC stays 0x10 and fetch_halted=1. A HLT fetched in the same cycle as branch_taken=1 must not halt.
- Wrap and async reset: PC=0xFFFE with a non-HLT instruction gives next PC=0x0000. Asserting rst_n=0 mid-cycle gives PC=0, IFID_valid=0, fetch_halted=0 before the next edge.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage of the 16-bit five-stage pipeline. Owns
//             the PC, drives the instruction-memory address, owns the IF/ID
//             pipeline register, honours hazard stalls, redirects on taken
//             branches and stops fetching once a HLT has been fetched.
//  Revision : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]        HLT_OPCODE = 4'b1111,
    parameter logic [DATA_W-1:0] NOP_INSTR  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PC_write_en,
    input  logic              IFID_write_en,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] imem_addr,
    output logic [DATA_W-1:0] IFID_instr,
    output logic [DATA_W-1:0] IFID_PC_plus2,
    output logic              IFID_valid,
    output logic              fetch_halted
);

    // Fetch FSM encoding
    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [DATA_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pcp2_q,  pcp2_d;
    logic              valid_q, valid_d;
    logic [0:0]        state_q, state_d;

    logic [DATA_W-1:0] pc_plus2;
    logic              is_hlt;

    // Sequential PC increment wraps silently at the top of the address space
    assign pc_plus2 = pc_q + DATA_W'(2);
    assign is_hlt   = (imem_data[DATA_W-1 -: 4] == HLT_OPCODE);

    // Next-state selection: stall beats branch, branch beats HLT, HLT beats
    // normal sequential fetch
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp2_d  = pcp2_q;
        valid_d = valid_q;
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (!IFID_write_en) begin
                    // Branch operands are unresolved during a stall, so a
                    // branch request is ignored here; IF/ID holds.
                    if (PC_write_en) begin
                        pc_d = pc_plus2;
                    end
                end else if (branch_taken) begin
                    // Squash the wrong-path fetch; PC_plus2 is left alone
                    pc_d    = branch_target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (is_hlt) begin
                    // Pass the HLT down the pipe and freeze the PC on it
                    instr_d = imem_data;
                    pcp2_d  = pc_plus2;
                    valid_d = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    instr_d = imem_data;
                    pcp2_d  = pc_plus2;
                    valid_d = 1'b1;
                    if (PC_write_en) begin
                        pc_d = pc_plus2;
                    end
                end
            end
            S_HALTED: begin
                // Only bubbles follow the HLT; a stall keeps the HLT visible
                if (IFID_write_en) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp2_q  <= '0;
            valid_q <= 1'b0;
            state_q <= S_RUN;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp2_q  <= pcp2_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign imem_addr     = pc_q;
    assign IFID_instr    = instr_q;
    assign IFID_PC_plus2 = pcp2_q;
    assign IFID_valid    = valid_q;
    assign fetch_halted  = (state_q == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed self-checking bench for if_stage. Each observation packs
//             {imem_addr, IFID_instr, IFID_PC_plus2, IFID_valid, fetch_halted}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_write_en;
    logic        IFID_write_en;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] IFID_instr;
    logic [15:0] IFID_PC_plus2;
    logic        IFID_valid;
    logic        fetch_halted;

    logic [15:0] mem [0:255];
    logic [49:0] obs;
    logic [49:0] exp_v;
    int          errors = 0;
    int          checks = 0;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_write_en   (PC_write_en),
        .IFID_write_en (IFID_write_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_data     (imem_data),
        .imem_addr     (imem_addr),
        .IFID_instr    (IFID_instr),
        .IFID_PC_plus2 (IFID_PC_plus2),
        .IFID_valid    (IFID_valid),
        .fetch_halted  (fetch_halted)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory (word index = addr[8:1])
    assign imem_data = mem[imem_addr[8:1]];
    assign obs       = {imem_addr, IFID_instr, IFID_PC_plus2, IFID_valid, fetch_halted};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; PC_write_en = 1'b1; IFID_write_en = 1'b1;
        branch_taken = 1'b0; branch_target = 16'h0000;
        #1;
        exp_v = {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_async: got %h want %h", obs, exp_v); end
        tick(); tick();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_held: got %h want %h", obs, exp_v); end
        rst_n = 1'b1;
    endtask

    task automatic test_seq_fetch();
        tick();
        exp_v = {16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL seq_0: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h0004, 16'h5678, 16'h0004, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL seq_1: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h0006, 16'h0ABC, 16'h0006, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL seq_2: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_stall();
        PC_write_en = 1'b0; IFID_write_en = 1'b0;
        exp_v = {16'h0006, 16'h0ABC, 16'h0006, 1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stall_%0d: got %h want %h", i, obs, exp_v); end
        end
        PC_write_en = 1'b1; IFID_write_en = 1'b1;
        tick();
        exp_v = {16'h0008, 16'h0001, 16'h0008, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_release: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_branch_flush();
        branch_taken = 1'b1; branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        exp_v = {16'h0040, 16'h0000, 16'h0008, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL branch_flush: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h0042, 16'h2222, 16'h0042, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL branch_target_fetch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_branch_during_stall();
        PC_write_en = 1'b0; IFID_write_en = 1'b0;
        branch_taken = 1'b1; branch_target = 16'h0080;
        tick();
        exp_v = {16'h0042, 16'h2222, 16'h0042, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL branch_in_stall: got %h want %h", obs, exp_v); end
        PC_write_en = 1'b1; IFID_write_en = 1'b1;
        tick();
        branch_taken = 1'b0;
        exp_v = {16'h0080, 16'h0000, 16'h0042, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL branch_after_stall: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_hlt();
        // mem[0x80] is a HLT, fetched while a branch is taken: must not halt
        branch_taken = 1'b1; branch_target = 16'h0010;
        tick();
        branch_taken = 1'b0;
        exp_v = {16'h0010, 16'h0000, 16'h0042, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hlt_with_branch: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hlt_fetch: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h0010, 16'h0000, 16'h0012, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hlt_bubble: got %h want %h", obs, exp_v); end
        branch_taken = 1'b1; branch_target = 16'h0020;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hlt_ignores_branch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_wrap_async_reset();
        // Mid-cycle reset must clear state before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset: got %h want %h", obs, exp_v); end
        tick();
        rst_n = 1'b1;
        branch_taken = 1'b1; branch_target = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        exp_v = {16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_setup: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h0000, 16'h4444, 16'h0000, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pc_wrap: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h1234;  // 0x0000
        mem[1]   = 16'h5678;  // 0x0002
        mem[2]   = 16'h0ABC;  // 0x0004
        mem[3]   = 16'h0001;  // 0x0006
        mem[4]   = 16'h0002;  // 0x0008
        mem[8]   = 16'hF000;  // 0x0010 HLT
        mem[32]  = 16'h2222;  // 0x0040
        mem[33]  = 16'h3333;  // 0x0042
        mem[64]  = 16'hF000;  // 0x0080 HLT (squashed by branch)
        mem[255] = 16'h4444;  // 0xFFFE

        test_reset();
        test_seq_fetch();
        test_stall();
        test_branch_flush();
        test_branch_during_stall();
        test_hlt();
        test_wrap_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
